// File: rtl/pc_sequencer_if.sv
// Fetch-stage bus between the PC sequencer and its environment (imem, decode, branch unit).
// Latency: n/a (signal bundle only).
// Backpressure: imem_ack paces fetch, stall holds the issued instruction.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        err;
    logic [1:0]  err_code;

    // Sequencer side
    modport master (
        output imem_req, imem_addr, pc, pc_plus4, instr_valid, err, err_code,
        input  imem_ack, stall, br_taken, br_target, jmp, jmp_target
    );

    // Environment side
    modport slave (
        input  imem_req, imem_addr, pc, pc_plus4, instr_valid, err, err_code,
        output imem_ack, stall, br_taken, br_target, jmp, jmp_target
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter controller: owns PC, runs the imem fetch handshake, selects next PC.
// Latency: 2 cycles per instruction minimum (FETCH with immediate ack, then ISSUE).
// Backpressure: waits in FETCH for imem_ack (bounded by ACK_TIMEOUT), holds ISSUE while stall=1.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [1:0]  r_err_code;
    logic [1:0]  w_err_code_nxt;
    logic        r_imem_req;
    logic        r_instr_valid;
    logic        r_err;

    logic [31:0] w_pc_plus4;
    logic        w_redirect;
    logic [31:0] w_pc_sel;

    // Incrementer wraps modulo 2^32; no alignment forcing on PC itself.
    assign w_pc_plus4 = r_pc + 32'd4;

    // Jump beats branch; only the selected target is subject to the alignment check.
    assign w_redirect = bus.jmp | bus.br_taken;
    assign w_pc_sel   = bus.jmp      ? bus.jmp_target :
                        bus.br_taken ? bus.br_target  : w_pc_plus4;

    // Next-state, next-PC, timeout counter and error code selection.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_cnt_nxt      = r_cnt;
        w_err_code_nxt = r_err_code;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
                w_cnt_nxt   = 8'd0;
            end
            S_FETCH: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (bus.imem_ack) begin
                    w_state_nxt = S_ISSUE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = CODE_TIMEOUT;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_ISSUE: begin
                // Redirects are only looked at when the instruction actually retires.
                if (!bus.stall) begin
                    if (w_redirect && (w_pc_sel[1:0] != 2'b00)) begin
                        w_state_nxt    = S_ERR;
                        w_err_code_nxt = CODE_MISALIGN;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_pc_nxt    = w_pc_sel;
                        w_cnt_nxt   = 8'd0;
                    end
                end
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any outstanding fetch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_cnt         <= 8'd0;
            r_err_code    <= CODE_NONE;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_err_code    <= w_err_code_nxt;
            r_imem_req    <= (w_state_nxt == S_FETCH);
            r_instr_valid <= (w_state_nxt == S_ISSUE);
            r_err         <= (w_state_nxt == S_ERR);
        end
    end

    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_pc;
    assign bus.pc          = r_pc;
    assign bus.pc_plus4    = w_pc_plus4;
    assign bus.instr_valid = r_instr_valid;
    assign bus.err         = r_err;
    assign bus.err_code    = r_err_code;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of the fetch/issue rules.
module tb_pc_sequencer;

    localparam logic [31:0] A_RESET_PC = 32'h0000_0000;
    localparam int          A_TO       = 4;
    localparam logic [31:0] B_RESET_PC = 32'hFFFF_FFFC;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_ISSUE = 2;
    localparam int P_ERR   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if a_if ();
    pc_sequencer_if b_if ();

    pc_sequencer #(.RESET_PC(A_RESET_PC), .ACK_TIMEOUT(A_TO)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (a_if.master)
    );

    pc_sequencer #(.RESET_PC(B_RESET_PC), .ACK_TIMEOUT(16)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (b_if.master)
    );

    // Second instance: always-ready memory, straight-line code from the top of the address space.
    assign b_if.imem_ack   = 1'b1;
    assign b_if.stall      = 1'b0;
    assign b_if.br_taken   = 1'b0;
    assign b_if.br_target  = 32'h0;
    assign b_if.jmp        = 1'b0;
    assign b_if.jmp_target = 32'h0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of instance A ----------------
    bit          m_known = 1'b0;
    int          m_phase = P_IDLE;
    logic [31:0] m_pc    = A_RESET_PC;
    int          m_age   = 0;       // cycles already spent waiting in the current fetch
    logic [1:0]  m_code  = 2'b00;

    always @(posedge clk) begin
        logic [31:0] dest;
        if (rst) begin
            m_known = 1'b1;
            m_phase = P_IDLE;
            m_pc    = A_RESET_PC;
            m_age   = 0;
            m_code  = 2'b00;
        end else if (m_known) begin
            if (m_phase == P_IDLE) begin
                m_phase = P_FETCH;
                m_age   = 0;
            end else if (m_phase == P_FETCH) begin
                if (a_if.imem_ack) m_phase = P_ISSUE;
                else if (m_age + 1 >= A_TO) begin
                    m_phase = P_ERR;
                    m_code  = 2'b10;
                end else m_age = m_age + 1;
            end else if (m_phase == P_ISSUE && !a_if.stall) begin
                if (a_if.jmp)           dest = a_if.jmp_target;
                else if (a_if.br_taken) dest = a_if.br_target;
                else                    dest = m_pc + 32'd4;
                if ((a_if.jmp || a_if.br_taken) && (dest % 4 != 0)) begin
                    m_phase = P_ERR;
                    m_code  = 2'b01;
                end else begin
                    m_pc    = dest;
                    m_phase = P_FETCH;
                    m_age   = 0;
                end
            end
        end
    end

    // Compare every cycle, mid-cycle, once the model has seen a reset.
    always @(negedge clk) begin
        if (m_known) begin
            check("m_imem_req",    {31'b0, a_if.imem_req},    {31'b0, m_phase == P_FETCH});
            check("m_imem_addr",   a_if.imem_addr,            m_pc);
            check("m_pc",          a_if.pc,                   m_pc);
            check("m_pc_plus4",    a_if.pc_plus4,             m_pc + 32'd4);
            check("m_instr_valid", {31'b0, a_if.instr_valid}, {31'b0, m_phase == P_ISSUE});
            check("m_err",         {31'b0, a_if.err},         {31'b0, m_phase == P_ERR});
            check("m_err_code",    {30'b0, a_if.err_code},    {30'b0, m_code});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_if.imem_ack   = 1'b0;
        a_if.stall      = 1'b0;
        a_if.br_taken   = 1'b0;
        a_if.br_target  = 32'h0;
        a_if.jmp        = 1'b0;
        a_if.jmp_target = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic to_issue();
        int n = 0;
        while (a_if.instr_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL issue_wait: actual=no_instr_valid required=instr_valid within 20 cycles");
        end
    endtask

    initial begin
        logic [31:0] tgt;
        clear_inputs();

        // Reset state and sequential flow from 0
        do_reset();
        check("rst_pc",        a_if.pc, 32'h0);
        check("rst_pc_plus4",  a_if.pc_plus4, 32'h4);
        check("rst_req",       {31'b0, a_if.imem_req}, 32'h0);
        check("rst_valid",     {31'b0, a_if.instr_valid}, 32'h0);
        check("rst_err",       {31'b0, a_if.err}, 32'h0);
        check("rst_code",      {30'b0, a_if.err_code}, 32'h0);
        check("b_rst_pc",      b_if.pc, 32'hFFFF_FFFC);
        check("b_rst_pc_plus4", b_if.pc_plus4, 32'h0);
        a_if.imem_ack = 1'b1;
        step();
        check("first_req",     {31'b0, a_if.imem_req}, 32'h1);
        check("first_addr",    a_if.imem_addr, 32'h0);
        check("first_valid",   {31'b0, a_if.instr_valid}, 32'h0);
        step();
        check("seq0_valid",    {31'b0, a_if.instr_valid}, 32'h1);
        check("seq0_pc",       a_if.pc, 32'h0);
        check("b_issue_pc",    b_if.pc, 32'hFFFF_FFFC);
        step();
        check("seq_alt_valid", {31'b0, a_if.instr_valid}, 32'h0);
        check("b_wrap_pc",     b_if.pc, 32'h0);
        step();
        check("seq1_pc",       a_if.pc, 32'h4);
        step();
        step();
        check("seq2_pc",       a_if.pc, 32'h8);

        // Stall holds PC and masks the branch
        a_if.stall = 1'b1;
        a_if.br_taken = 1'b1;
        a_if.br_target = 32'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc",    a_if.pc, 32'h8);
            check("stall_valid", {31'b0, a_if.instr_valid}, 32'h1);
        end
        a_if.stall = 1'b0;
        a_if.br_taken = 1'b0;
        step();
        step();
        check("post_stall_pc",    a_if.pc, 32'hC);
        check("post_stall_valid", {31'b0, a_if.instr_valid}, 32'h1);

        // Wrap at the top of the address space, then jump-over-branch priority
        a_if.jmp = 1'b1;
        a_if.jmp_target = 32'hFFFF_FFFC;
        step();
        a_if.jmp = 1'b0;
        step();
        check("top_pc",        a_if.pc, 32'hFFFF_FFFC);
        check("top_pc_plus4",  a_if.pc_plus4, 32'h0);
        step();
        step();
        check("wrap_pc",       a_if.pc, 32'h0);
        a_if.jmp = 1'b1;
        a_if.jmp_target = 32'h40;
        a_if.br_taken = 1'b1;
        a_if.br_target = 32'h80;
        step();
        a_if.jmp = 1'b0;
        a_if.br_taken = 1'b0;
        check("prio_pc",       a_if.pc, 32'h40);

        // Misaligned jump target is terminal and keeps the faulting PC
        do_reset();
        a_if.imem_ack = 1'b1;
        repeat (4) step();
        check("mis_pre_pc",    a_if.pc, 32'h4);
        a_if.jmp = 1'b1;
        a_if.jmp_target = 32'h42;
        step();
        a_if.jmp = 1'b0;
        check("mis_err",       {31'b0, a_if.err}, 32'h1);
        check("mis_code",      {30'b0, a_if.err_code}, 32'h1);
        check("mis_pc",        a_if.pc, 32'h4);
        check("mis_req",       {31'b0, a_if.imem_req}, 32'h0);
        repeat (3) step();
        check("mis_hold_err",  {31'b0, a_if.err}, 32'h1);
        check("mis_hold_pc",   a_if.pc, 32'h4);
        check("mis_hold_req",  {31'b0, a_if.imem_req}, 32'h0);

        // Fetch timeout after four unanswered FETCH cycles
        do_reset();
        repeat (4) step();
        check("to_pre_req",    {31'b0, a_if.imem_req}, 32'h1);
        check("to_pre_err",    {31'b0, a_if.err}, 32'h0);
        step();
        check("to_err",        {31'b0, a_if.err}, 32'h1);
        check("to_code",       {30'b0, a_if.err_code}, 32'h2);
        check("to_req",        {31'b0, a_if.imem_req}, 32'h0);

        // Ack on the last allowed FETCH cycle wins
        do_reset();
        repeat (4) step();
        a_if.imem_ack = 1'b1;
        step();
        check("late_ack_valid", {31'b0, a_if.instr_valid}, 32'h1);
        check("late_ack_err",   {31'b0, a_if.err}, 32'h0);

        // Reset in the middle of a fetch at 0x20, with ack on the same edge
        do_reset();
        a_if.imem_ack = 1'b1;
        to_issue();
        a_if.jmp = 1'b1;
        a_if.jmp_target = 32'h20;
        a_if.imem_ack = 1'b0;
        step();
        a_if.jmp = 1'b0;
        check("mid_pc",        a_if.pc, 32'h20);
        check("mid_req",       {31'b0, a_if.imem_req}, 32'h1);
        rst = 1'b1;
        a_if.imem_ack = 1'b1;
        step();
        rst = 1'b0;
        a_if.imem_ack = 1'b0;
        check("mid_rst_pc",    a_if.pc, A_RESET_PC);
        check("mid_rst_req",   {31'b0, a_if.imem_req}, 32'h0);
        check("mid_rst_valid", {31'b0, a_if.instr_valid}, 32'h0);
        step();
        check("mid_refetch_req",   {31'b0, a_if.imem_req}, 32'h1);
        check("mid_refetch_valid", {31'b0, a_if.instr_valid}, 32'h0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (m_phase == P_ERR) rst = ($urandom_range(0, 7) == 0);
            else                  rst = ($urandom_range(0, 299) == 0);
            a_if.imem_ack = ($urandom_range(0, 99) < 55);
            a_if.stall    = ($urandom_range(0, 99) < 30);
            a_if.jmp      = ($urandom_range(0, 99) < 12);
            a_if.br_taken = ($urandom_range(0, 99) < 25);
            tgt = $urandom;
            tgt[1:0] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            a_if.jmp_target = tgt;
            tgt = $urandom;
            tgt[1:0] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            a_if.br_target = tgt;
            step();
        end
        rst = 1'b0;
        clear_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter controller for the fetch stage of the single-cycle datapath.
- Owns the PC register and drives the ADD4 incrementer path.
- Selects next PC from PC+4, branch target or jump target.
- Runs the instruction-memory fetch handshake; adds stall, alignment check and fetch-timeout error handling.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ACK_TIMEOUT, 16, max FETCH cycles without IMEM_ACK before error (legal range 2..255).

Ports:
CLK  input  1  clock, rising-edge.
RST  input  1  synchronous, active-high reset.
IMEM_REQ  output  1  fetch request to instruction memory.
IMEM_ADDR  output  32  fetch address; always equals PC.
IMEM_ACK  input  1  instruction memory has returned data for IMEM_ADDR.
STALL  input  1  downstream cannot accept; hold current instruction.
BR_TAKEN  input  1  branch resolved taken.
BR_TARGET  input  32  branch target address.
JMP  input  1  jump request.
JMP_TARGET  input  32  jump target address.
PC  output  32  current program counter.
PC_PLUS4  output  32  PC + 4, combinational, modulo 2^32.
INSTR_VALID  output  1  instruction at PC is valid for decode.
ERR  output  1  sticky error flag.
ERR_CODE  output  2  00 none, 01 misaligned target, 10 fetch timeout.

Behaviour:
- Reset behaviour: sampled on rising CLK while RST=1. Resulting state:
  - state IDLE, PC=RESET_PC, PC_PLUS4=RESET_PC+4.
  - IMEM_REQ=0, INSTR_VALID=0, ERR=0, ERR_CODE=00, timeout counter=0.
- RST=1 overrides everything, in any state and mid-fetch. An outstanding fetch is abandoned and a late IMEM_ACK is ignored.
- IDLE: outputs inactive. Next cycle goes to FETCH unconditionally, so the first IMEM_REQ appears 1 cycle after RST deasserts.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC.
  - IMEM_ACK=1 at an edge -> ISSUE.
  - Otherwise the 8-bit counter increments.
  - Counter reaching ACK_TIMEOUT-1 with IMEM_ACK=0 -> ERR, code 10.
  - ACK arriving on the timeout cycle wins: go to ISSUE.
  - Counter clears on every FETCH entry.
- ISSUE: INSTR_VALID=1, IMEM_REQ=0.
  - STALL=1: stay in ISSUE; PC and INSTR_VALID held; BR_TAKEN/JMP ignored.
  - STALL=0: PC <= next PC, state -> FETCH.
- Next-PC priority: JMP ? JMP_TARGET : BR_TAKEN ? BR_TARGET : PC_PLUS4. Both JMP and BR_TAKEN set -> jump wins.
- Redirect inputs are sampled only in ISSUE with STALL=0. In IDLE, FETCH or ERR they are ignored and never queued.
- Alignment: selected redirect target with bits[1:0] != 00 -> ERR, code 01.
  - PC not updated; it keeps the faulting instruction's address.
  - Misaligned value on the non-selected target is ignored.
- Wrap-around: PC=32'hFFFF_FFFC sequential -> PC=32'h0000_0000. PC_PLUS4 of 32'hFFFF_FFFF is 32'h0000_0003 (RESET_PC not forced aligned; sequential flow from a misaligned RESET_PC is not checked).
- ERR: terminal until RST. ERR=1, ERR_CODE held, IMEM_REQ=0, INSTR_VALID=0, PC frozen.
- Throughput: minimum 2 cycles per instruction (FETCH with immediate ACK, then ISSUE).
- All outputs registered except PC_PLUS4 and IMEM_ADDR, which are direct functions of the PC register.

Test Plan:
- Reset/sequential: RESET_PC=0, ACK tied 1, STALL=0, 4 instructions.
  -> PC sequence 0,4,8,12.
  -> INSTR_VALID on alternate cycles.
  -> IMEM_REQ first high 1 cycle after RST falls.
- Wrap and priority:
  - RESET_PC=32'hFFFF_FFFC, no redirect -> PC 32'h0000_0000 next.
  - Then JMP=1 (JMP_TARGET=32'h0000_0040) and BR_TAKEN=1 (BR_TARGET=32'h0000_0080) together in ISSUE -> PC=32'h40.
- Stall and redirect masking: in ISSUE at PC=8, STALL=1 for 3 cycles with BR_TAKEN=1, BR_TARGET=32'h100.
  -> PC stays 8, INSTR_VALID=1 throughout.
  -> Release STALL with BR_TAKEN=0: PC=12.
- Misaligned: JMP=1, JMP_TARGET=32'h0000_0042 in ISSUE at PC=4.
  -> ERR=1, ERR_CODE=01, PC remains 4, IMEM_REQ=0 until RST.
- Timeout: ACK_TIMEOUT=4, IMEM_ACK held 0.
  -> ERR_CODE=10 after 4 FETCH cycles.
  -> Repeat with ACK=1 on 4th cycle: ISSUE, no error.
- Reset mid-fetch: RST pulsed 1 cycle while in FETCH at PC=32'h20, ACK asserted same cycle.
  -> PC=RESET_PC, IMEM_REQ=0 next cycle, no INSTR_VALID for the abandoned fetch.
